// File: rtl/conv5_rm_pkg.sv
// conv5_rm_pkg: shared constants and read-FSM state type for the conv5 row-memory
package conv5_rm_pkg;
    localparam int RM_ADDR_W = 12;
    localparam int RM_DATA_W = 64;
    localparam int RM_DEPTH  = 2496;
    localparam int RM_RD_LAT = 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;
endpackage

// File: rtl/conv5_rm_ofifo.sv
// conv5_rm_ofifo: first-word-fall-through FIFO with occupancy count
module conv5_rm_ofifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    // storage array, no reset needed since the head is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    // pointers and count; a push into a full FIFO without a pop is a design error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && !pop && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign dout = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/conv5_rm_rd_ctrl.sv
// conv5_rm_rd_ctrl: credit-protected burst reader from the row-memory RAM to a valid/ready stream (optional m_last via CONV5_RM_RD_LAST_EN)
module conv5_rm_rd_ctrl
    import conv5_rm_pkg::*;
#(
    parameter int ADDR_W     = RM_ADDR_W,
    parameter int DATA_W     = RM_DATA_W,
    parameter int MEM_DEPTH  = RM_DEPTH,
    parameter int RD_LAT     = RM_RD_LAT,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
`ifdef CONV5_RM_RD_LAST_EN
    ,
    output logic              m_last
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef CONV5_RM_RD_LAST_EN
    localparam int FW = DATA_W + 1;
`else
    localparam int FW = DATA_W;
`endif
    rd_state_t         state, nstate;
    logic [ADDR_W-1:0] addr, last_addr;
    logic [LEN_W-1:0]  remaining;
    logic [CW-1:0]     inflight, fifo_count;
    logic [CW:0]       occupancy;
    logic [RD_LAT-1:0] vld_pipe;
    logic              issue, push, pop, done_d, last_issue;
    logic [FW-1:0]     fifo_din, fifo_dout;

    assign occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue      = (state == RUN) && (remaining != '0) && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign last_issue = issue && (remaining == LEN_W'(1));
    assign push       = vld_pipe[RD_LAT-1];
    assign m_valid    = fifo_count != '0;
    assign pop        = m_valid && m_ready;
    assign busy       = state != IDLE;
    assign done       = done_d;
    assign ram_addrb  = issue ? addr : last_addr;

    // next state and done request; DRAIN finishes on the final accepted word
    logic done_nx;
    always_comb begin
        nstate  = state;
        done_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nstate  = (num_words != '0) ? RUN : IDLE;
                    done_nx = num_words == '0;
                end
            end
            RUN: nstate = last_issue ? DRAIN : RUN;
            DRAIN: begin
                if (inflight == '0 && (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
                    nstate  = IDLE;
                    done_nx = 1'b1;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // state register and registered done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_d <= 1'b0;
        end else begin
            state  <= nstate;
            done_d <= done_nx;
        end
    end

    // burst address/length bookkeeping; the wrap keeps addresses inside the ring buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            last_addr <= '0;
            remaining <= '0;
        end else if (state == IDLE && start) begin
            addr      <= base_addr;
            remaining <= num_words;
        end else if (issue) begin
            addr      <= (addr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
            last_addr <= addr;
            remaining <= remaining - LEN_W'(1);
        end
    end

    // read-latency valid pipe and count of reads not yet landed in the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            inflight <= '0;
        end else begin
            vld_pipe <= RD_LAT'({vld_pipe, issue});
            inflight <= inflight + CW'(issue) - CW'(push);
        end
    end

`ifdef CONV5_RM_RD_LAST_EN
    logic [RD_LAT-1:0] last_pipe;
    // last-word flag travels alongside the valid pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_pipe <= '0;
        else last_pipe <= RD_LAT'({last_pipe, last_issue});
    end
    assign fifo_din = {last_pipe[RD_LAT-1], ram_doutb};
    assign m_last   = fifo_dout[DATA_W];
`else
    assign fifo_din = ram_doutb;
`endif
    assign m_data = fifo_dout[DATA_W-1:0];

    conv5_rm_ofifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_ofifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );
endmodule
